vram_bus_arbiter: RTL and testbench
===================================

VRAM_BUS_ARBITER -- requirements
Module: vram_bus_arbiter

Interface
REQ-001 SHALL have ports: clk1 in 1 (sole clock, rising edge); reset in 1 (asynchronous, active-high).
REQ-002 SHALL have ppu_req in 1, ppu_addr in 13, ppu_ack out 1: PPU fetcher read port.
REQ-003 SHALL have dma_req in 1, dma_addr in 13, dma_ack out 1: OAM-DMA VRAM source read port.
REQ-004 SHALL have cpu_req in 1, cpu_we in 1, cpu_addr in 13, cpu_wdata in 8, cpu_ack out 1: CPU port.
REQ-005 SHALL have rdata out 8: read data for whichever port is acked.
REQ-006 SHALL have ppu_mode3 in 1: PPU pixel-transfer phase, VRAM owned by PPU.
REQ-007 SHALL have ma_out out 13, md_out out 8, md_drive out 1, mcs out 1, moe out 1, mwr out 1: VRAM pins, active-high.

Function
REQ-008 SHALL implement FSM states IDLE, ADDR, DATA, ACK.
REQ-009 SHALL arbitrate only in IDLE with fixed priority PPU > DMA > CPU, latching winner, address, we and wdata.
REQ-010 SHALL go IDLE->ADDR on any eligible request, ADDR->DATA, DATA->ACK, ACK->IDLE unconditionally.
REQ-011 SHALL drive ma_out with latched address and mcs=1 in ADDR and DATA; ma_out holds last value elsewhere.
REQ-012 SHALL assert moe in ADDR and DATA for reads; mwr only in DATA for writes; md_drive and md_out=wdata in ADDR and DATA for writes.
REQ-013 SHALL register md_in into rdata on the clock edge leaving DATA for reads; writes leave rdata unchanged.
REQ-014 SHALL pulse the winner's ack for exactly one cycle in ACK; total latency request-seen-in-IDLE to ack = 3 cycles.
REQ-015 SHALL treat req as level, held until ack; a request whose ack is high in the current cycle is ineligible that cycle.
REQ-016 SHALL, with lock enabled and ppu_mode3 or dma_req high in IDLE, serve a winning CPU request without bus access: go directly to ACK, rdata=8'hFF for reads, writes discarded.
REQ-017 SHALL leave an in-flight transaction unaffected by ppu_mode3 changes after arbitration.
REQ-018 SHALL tolerate simultaneous requests from all three ports; losers stay pending, no request lost.

Reset
REQ-019 SHALL on reset high immediately force IDLE, all acks 0, mcs/moe/mwr/md_drive 0, ma_out 0, md_out 0, rdata 8'h00, regardless of phase.
REQ-020 SHALL abort an in-flight transaction on reset without ack; requester re-issues after reset.

Configuration
REQ-021 SHALL honour macro DMG_VRAM_LOCK_EN: defined -> REQ-016 lock active; undefined -> CPU always arbitrates normally, ppu_mode3 ignored.

Structure
REQ-022 SHALL place FSM state enum, port-id encoding (PPU=0, DMA=1, CPU=2) and VRAM_AW=13 constant in shared package dmg_pkg.
REQ-023 SHALL contain one sub-module vram_prio_enc (3-input fixed-priority encoder with eligibility masks).

Verification
REQ-024 SHALL test single CPU read addr 13'h0010, md_in=8'h5A -> mcs/moe 2 cycles, cpu_ack 3 cycles after, rdata=8'h5A.
REQ-025 SHALL test CPU write addr 13'h1FFF data 8'hC3 -> mwr 1 cycle in DATA, md_out=8'hC3, md_drive 2 cycles, cpu_ack once.
REQ-026 SHALL test PPU, DMA, CPU requesting together -> acks in order ppu, dma, cpu, 4 cycles apart.
REQ-027 SHALL test with DMG_VRAM_LOCK_EN, ppu_mode3=1, CPU read -> no mcs, cpu_ack after 1 cycle, rdata=8'hFF; without macro -> normal 3-cycle read.
REQ-028 SHALL test reset asserted during DATA -> strobes low same cycle, no ack, IDLE after release, pending request served next.

Source files
------------

// File: rtl/dmg_pkg.sv
// rtl/dmg_pkg.sv - shared types and constants for the VRAM bus arbiter
// Contents: arbiter FSM state enum, requester port ids (PPU=0, DMA=1, CPU=2),
// VRAM address width.
package dmg_pkg;

  localparam int VRAM_AW = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  // Also used as the bit index of each port in req/ack vectors.
  typedef enum logic [1:0] {
    PORT_PPU = 2'd0,
    PORT_DMA = 2'd1,
    PORT_CPU = 2'd2
  } port_id_t;

endpackage

// File: rtl/vram_bus_arbiter_if.sv
// rtl/vram_bus_arbiter_if.sv - requester ports and VRAM pins of the arbiter
// Signals: ppu/dma read ports (req, addr, ack), cpu port (req, we, addr, wdata, ack),
// shared rdata, ppu_mode3, VRAM pins (ma_out, md_out, md_drive, mcs, moe, mwr, md_in).
// Modports: master = requesters plus VRAM device side, slave = arbiter.
interface vram_bus_arbiter_if;
  import dmg_pkg::*;

  logic               ppu_req;
  logic [VRAM_AW-1:0] ppu_addr;
  logic               ppu_ack;
  logic               dma_req;
  logic [VRAM_AW-1:0] dma_addr;
  logic               dma_ack;
  logic               cpu_req;
  logic               cpu_we;
  logic [VRAM_AW-1:0] cpu_addr;
  logic [7:0]         cpu_wdata;
  logic               cpu_ack;
  logic [7:0]         rdata;
  logic               ppu_mode3;
  logic [VRAM_AW-1:0] ma_out;
  logic [7:0]         md_out;
  logic               md_drive;
  logic               mcs;
  logic               moe;
  logic               mwr;
  logic [7:0]         md_in;

  modport master (
    output ppu_req, ppu_addr, dma_req, dma_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ppu_mode3, md_in,
    input  ppu_ack, dma_ack, cpu_ack, rdata,
    input  ma_out, md_out, md_drive, mcs, moe, mwr
  );

  modport slave (
    input  ppu_req, ppu_addr, dma_req, dma_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ppu_mode3, md_in,
    output ppu_ack, dma_ack, cpu_ack, rdata,
    output ma_out, md_out, md_drive, mcs, moe, mwr
  );

endinterface

// File: rtl/vram_prio_enc.sv
// rtl/vram_prio_enc.sv - 3-input fixed-priority encoder (PPU > DMA > CPU)
// Ports: req[2:0] raw request levels indexed by port id, elig[2:0] eligibility
// mask, grant_valid any eligible request, grant_id winning port.
module vram_prio_enc
  import dmg_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] elig,
  output logic       grant_valid,
  output port_id_t   grant_id
);

  logic [2:0] live;

  always_comb begin
    live        = req & elig;
    grant_valid = |live;
    grant_id    = PORT_CPU;
    if (live[PORT_PPU]) begin
      grant_id = PORT_PPU;
    end else if (live[PORT_DMA]) begin
      grant_id = PORT_DMA;
    end
  end

endmodule

// File: rtl/vram_bus_arbiter.sv
// rtl/vram_bus_arbiter.sv - VRAM bus arbiter for PPU fetcher, OAM-DMA and CPU
// Ports: clk1 (rising edge), reset (async, active-high), bus (vram_bus_arbiter_if.slave).
// Each access runs IDLE -> ADDR -> DATA -> ACK; ack appears 3 cycles after the
// request is seen in IDLE. Optional build macro DMG_VRAM_LOCK_EN: while ppu_mode3
// or dma_req is high, a winning CPU request is answered in ACK without touching
// the bus (reads return 8'hFF, writes are dropped).
module vram_bus_arbiter
  import dmg_pkg::*;
(
  input logic               clk1,
  input logic               reset,
  vram_bus_arbiter_if.slave bus
);

  arb_state_t         state, state_nxt;
  port_id_t           winner_q;
  port_id_t           grant_id;
  logic               grant_valid;
  logic [VRAM_AW-1:0] addr_q, sel_addr;
  logic               we_q, sel_we;
  logic [7:0]         wdata_q, rdata_q;
  logic [2:0]         req_vec, ack_vec, elig;
  logic               bypass;
  logic               bus_phase;

  assign req_vec = {bus.cpu_req, bus.dma_req, bus.ppu_req};
  // A port whose ack is high this cycle is finishing and must not re-win.
  assign elig    = ~ack_vec;

  vram_prio_enc u_prio_enc (
    .req         (req_vec),
    .elig        (elig),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

`ifdef DMG_VRAM_LOCK_EN
  assign bypass = (grant_id == PORT_CPU) && (bus.ppu_mode3 || bus.dma_req);
`else
  logic unused_mode3;
  assign bypass       = 1'b0;
  assign unused_mode3 = bus.ppu_mode3;
`endif

  always_comb begin
    sel_addr = bus.cpu_addr;
    case (grant_id)
      PORT_PPU: sel_addr = bus.ppu_addr;
      PORT_DMA: sel_addr = bus.dma_addr;
      default:  sel_addr = bus.cpu_addr;
    endcase
  end

  assign sel_we = (grant_id == PORT_CPU) && bus.cpu_we;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_valid) state_nxt = bypass ? ST_ACK : ST_ADDR;
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: state_nxt = ST_ACK;
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/we/wdata are only reloaded for real bus cycles so ma_out keeps its
  // last value across a locked CPU access.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      winner_q <= PORT_PPU;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
    end else begin
      if (state == ST_IDLE && grant_valid) begin
        winner_q <= grant_id;
        if (!bypass) begin
          addr_q  <= sel_addr;
          we_q    <= sel_we;
          wdata_q <= bus.cpu_wdata;
        end else if (!bus.cpu_we) begin
          rdata_q <= 8'hFF;
        end
      end
      if (state == ST_DATA && !we_q) begin
        rdata_q <= bus.md_in;
      end
    end
  end

  always_comb begin
    ack_vec = 3'b000;
    if (state == ST_ACK) ack_vec[winner_q] = 1'b1;
  end

  assign bus_phase    = (state == ST_ADDR) || (state == ST_DATA);
  assign bus.ppu_ack  = ack_vec[PORT_PPU];
  assign bus.dma_ack  = ack_vec[PORT_DMA];
  assign bus.cpu_ack  = ack_vec[PORT_CPU];
  assign bus.rdata    = rdata_q;
  assign bus.ma_out   = addr_q;
  assign bus.mcs      = bus_phase;
  assign bus.moe      = bus_phase && !we_q;
  assign bus.mwr      = (state == ST_DATA) && we_q;
  assign bus.md_drive = bus_phase && we_q;
  assign bus.md_out   = (bus_phase && we_q) ? wdata_q : 8'h00;

endmodule

// File: tb/tb_vram_bus_arbiter.sv
// tb/tb_vram_bus_arbiter.sv - self-checking bench for vram_bus_arbiter
module tb_vram_bus_arbiter;
  import dmg_pkg::*;

  logic clk1 = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] vram [8192];
  logic [7:0] ref_mem [8192];
  logic [7:0] model_rdata;

  vram_bus_arbiter_if vif ();

  vram_bus_arbiter dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk1 = ~clk1;

  function automatic logic [7:0] init_val(input int a);
    logic [7:0] v;
    v = 8'(a * 7 + 3);
    if (a == 16) v = 8'h5A;
    return v;
  endfunction

  // VRAM device: asynchronous read while moe, write on the edge where mwr is high.
  assign vif.md_in = vif.moe ? vram[vif.ma_out] : 8'h00;

  always @(posedge clk1) begin
    if (mem_init) begin
      for (int i = 0; i < 8192; i++) vram[i] <= init_val(i);
    end else if (vif.mwr) begin
      vram[vif.ma_out] <= vif.md_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_req(input int port, input logic lvl, input logic we,
                         input logic [12:0] addr, input logic [7:0] wdata);
    case (port)
      0: begin vif.ppu_req = lvl; vif.ppu_addr = addr; end
      1: begin vif.dma_req = lvl; vif.dma_addr = addr; end
      default: begin
        vif.cpu_req = lvl; vif.cpu_we = we; vif.cpu_addr = addr; vif.cpu_wdata = wdata;
      end
    endcase
  endtask

  function automatic logic port_ack(input int port);
    case (port)
      0: return vif.ppu_ack;
      1: return vif.dma_ack;
      default: return vif.cpu_ack;
    endcase
  endfunction

  // Issues one request at the current negedge and watches 8 cycles.
  task automatic run_one(input int port, input logic we, input logic [12:0] addr,
                         input logic [7:0] wdata,
                         output int mcs_cnt, output int moe_cnt, output int mwr_cnt,
                         output int drv_cnt, output int ack_cyc, output int ack_cnt,
                         output logic [7:0] md_seen, output logic [7:0] rd_at_ack);
    mcs_cnt = 0; moe_cnt = 0; mwr_cnt = 0; drv_cnt = 0;
    ack_cyc = -1; ack_cnt = 0; md_seen = 8'h00; rd_at_ack = 8'h00;
    set_req(port, 1'b1, we, addr, wdata);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk1); @(negedge clk1);
      if (vif.mcs) mcs_cnt++;
      if (vif.moe) moe_cnt++;
      if (vif.mwr) begin mwr_cnt++; md_seen = vif.md_out; end
      if (vif.md_drive) drv_cnt++;
      if (port_ack(port)) begin
        ack_cnt++;
        if (ack_cyc < 0) begin ack_cyc = i; rd_at_ack = vif.rdata; end
        set_req(port, 1'b0, 1'b0, 13'h0, 8'h00);
      end
    end
  endtask

  task automatic test_reset();
    vif.ppu_req = 0; vif.ppu_addr = '0; vif.dma_req = 0; vif.dma_addr = '0;
    vif.cpu_req = 0; vif.cpu_we = 0; vif.cpu_addr = '0; vif.cpu_wdata = '0;
    vif.ppu_mode3 = 0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    @(posedge clk1); @(negedge clk1);
    mem_init = 1'b0;
    tests++;
    if ({vif.ppu_ack, vif.dma_ack, vif.cpu_ack} !== 3'b000) begin
      fails++; $display("FAIL reset_acks got=%b want=000", {vif.ppu_ack, vif.dma_ack, vif.cpu_ack});
    end
    tests++;
    if ({vif.mcs, vif.moe, vif.mwr, vif.md_drive} !== 4'b0000) begin
      fails++; $display("FAIL reset_strobes got=%b want=0000", {vif.mcs, vif.moe, vif.mwr, vif.md_drive});
    end
    tests++;
    if (vif.ma_out !== 13'h0 || vif.md_out !== 8'h00 || vif.rdata !== 8'h00) begin
      fails++; $display("FAIL reset_values ma=%h md=%h rdata=%h want 0/0/0", vif.ma_out, vif.md_out, vif.rdata);
    end
    reset = 1'b0;
    model_rdata = 8'h00;
    @(posedge clk1); @(negedge clk1);
  endtask

  task automatic test_cpu_read();
    int mc, mo, mw, dr, ac, an; logic [7:0] md, rd;
    run_one(2, 1'b0, 13'h0010, 8'h00, mc, mo, mw, dr, ac, an, md, rd);
    model_rdata = ref_mem[16];
    tests++;
    if (mc != 2 || mo != 2) begin fails++; $display("FAIL read_strobes mcs=%0d moe=%0d want 2/2", mc, mo); end
    tests++;
    if (ac != 3 || an != 1) begin fails++; $display("FAIL read_ack cycle=%0d count=%0d want 3/1", ac, an); end
    tests++;
    if (rd !== 8'h5A) begin fails++; $display("FAIL read_rdata got=%h want=5a", rd); end
  endtask

  task automatic test_cpu_write();
    int mc, mo, mw, dr, ac, an; logic [7:0] md, rd;
    run_one(2, 1'b1, 13'h1FFF, 8'hC3, mc, mo, mw, dr, ac, an, md, rd);
    ref_mem[13'h1FFF] = 8'hC3;
    tests++;
    if (mw != 1 || dr != 2 || mc != 2 || mo != 0) begin
      fails++; $display("FAIL write_strobes mwr=%0d drive=%0d mcs=%0d moe=%0d want 1/2/2/0", mw, dr, mc, mo);
    end
    tests++;
    if (md !== 8'hC3) begin fails++; $display("FAIL write_md_out got=%h want=c3", md); end
    tests++;
    if (an != 1 || ac != 3) begin fails++; $display("FAIL write_ack count=%0d cycle=%0d want 1/3", an, ac); end
    tests++;
    if (vram[13'h1FFF] !== 8'hC3 || rd !== model_rdata) begin
      fails++; $display("FAIL write_effect mem=%h rdata=%h want c3/%h", vram[13'h1FFF], rd, model_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int ack_at [3];
    int ack_n [3];
    for (int p = 0; p < 3; p++) begin ack_at[p] = -1; ack_n[p] = 0; end
    set_req(0, 1'b1, 1'b0, 13'h0101, 8'h00);
    set_req(1, 1'b1, 1'b0, 13'h0102, 8'h00);
    set_req(2, 1'b1, 1'b0, 13'h0103, 8'h00);
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk1); @(negedge clk1);
      for (int p = 0; p < 3; p++) begin
        if (port_ack(p)) begin
          ack_n[p]++;
          if (ack_at[p] < 0) ack_at[p] = i;
          set_req(p, 1'b0, 1'b0, 13'h0, 8'h00);
        end
      end
    end
    model_rdata = ref_mem[13'h0103];
    tests++;
    if (ack_at[0] != 3 || ack_at[1] != 7 || ack_at[2] != 11) begin
      fails++; $display("FAIL b2b_order ppu=%0d dma=%0d cpu=%0d want 3/7/11", ack_at[0], ack_at[1], ack_at[2]);
    end
    tests++;
    if (ack_n[0] != 1 || ack_n[1] != 1 || ack_n[2] != 1 || vif.rdata !== model_rdata) begin
      fails++; $display("FAIL b2b_counts %0d/%0d/%0d rdata=%h want 1/1/1 %h",
                        ack_n[0], ack_n[1], ack_n[2], vif.rdata, model_rdata);
    end
  endtask

  task automatic test_lock();
    int mc, mo, mw, dr, ac, an; logic [7:0] md, rd;
    int want_mcs, want_ac; logic [7:0] want_rd;
    vif.ppu_mode3 = 1'b1;
    run_one(2, 1'b0, 13'h0010, 8'h00, mc, mo, mw, dr, ac, an, md, rd);
    vif.ppu_mode3 = 1'b0;
`ifdef DMG_VRAM_LOCK_EN
    want_mcs = 0; want_ac = 1; want_rd = 8'hFF;
`else
    want_mcs = 2; want_ac = 3; want_rd = ref_mem[16];
`endif
    model_rdata = want_rd;
    tests++;
    if (mc != want_mcs) begin fails++; $display("FAIL lock_mcs got=%0d want=%0d", mc, want_mcs); end
    tests++;
    if (ac != want_ac || an != 1) begin fails++; $display("FAIL lock_ack cycle=%0d count=%0d want %0d/1", ac, an, want_ac); end
    tests++;
    if (rd !== want_rd) begin fails++; $display("FAIL lock_rdata got=%h want=%h", rd, want_rd); end
  endtask

  task automatic test_reset_in_data();
    int dma_at, cpu_at; logic [7:0] dma_rd, cpu_rd;
    dma_at = -1; cpu_at = -1; dma_rd = 0; cpu_rd = 0;
    set_req(2, 1'b1, 1'b0, 13'h0020, 8'h00);
    @(posedge clk1); @(negedge clk1);
    @(posedge clk1); @(negedge clk1);
    set_req(1, 1'b1, 1'b0, 13'h0030, 8'h00);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({vif.mcs, vif.moe, vif.cpu_ack, vif.dma_ack} !== 4'b0000 || vif.rdata !== 8'h00 || vif.ma_out !== 13'h0) begin
      fails++; $display("FAIL rst_data_immediate strobes=%b rdata=%h ma=%h want 0000/00/0",
                        {vif.mcs, vif.moe, vif.cpu_ack, vif.dma_ack}, vif.rdata, vif.ma_out);
    end
    @(posedge clk1); @(negedge clk1);
    tests++;
    if ({vif.mcs, vif.ppu_ack, vif.dma_ack, vif.cpu_ack} !== 4'b0000) begin
      fails++; $display("FAIL rst_data_held got=%b want=0000", {vif.mcs, vif.ppu_ack, vif.dma_ack, vif.cpu_ack});
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk1); @(negedge clk1);
      if (vif.dma_ack && dma_at < 0) begin dma_at = i; dma_rd = vif.rdata; set_req(1, 1'b0, 1'b0, 13'h0, 8'h00); end
      if (vif.cpu_ack && cpu_at < 0) begin cpu_at = i; cpu_rd = vif.rdata; set_req(2, 1'b0, 1'b0, 13'h0, 8'h00); end
    end
    model_rdata = ref_mem[13'h0020];
    tests++;
    if (dma_at != 3 || cpu_at != 7) begin
      fails++; $display("FAIL rst_data_resume dma=%0d cpu=%0d want 3/7", dma_at, cpu_at);
    end
    tests++;
    if (dma_rd !== ref_mem[13'h0030] || cpu_rd !== ref_mem[13'h0020]) begin
      fails++; $display("FAIL rst_data_rdata dma=%h cpu=%h want %h/%h", dma_rd, cpu_rd,
                        ref_mem[13'h0030], ref_mem[13'h0020]);
    end
  endtask

  // Reference: one transaction at a time, highest-priority pending port wins in
  // a free cycle, its ack lands 3 cycles later (1 when a locked CPU access).
  task automatic test_random();
    logic        active [3];
    logic [12:0] t_addr [3];
    logic        t_we;
    logic [7:0]  t_wdata;
    int free_at, ack_at, busy, bus_lo, bus_hi, win;
    logic [12:0] exp_addr;
    logic [7:0]  exp_rdata;
    logic [2:0]  got_ack, exp_ack;
    logic        byp, exp_mcs;
    int          left;
    for (int p = 0; p < 3; p++) begin active[p] = 1'b0; t_addr[p] = '0; end
    t_we = 0; t_wdata = 0;
    free_at = 0; ack_at = -1; busy = 0; bus_lo = 1; bus_hi = 0;
    exp_addr = '0; exp_rdata = model_rdata;
    for (int cyc = 0; cyc < 400; cyc++) begin
      got_ack = {vif.cpu_ack, vif.dma_ack, vif.ppu_ack};
      exp_ack = (cyc == ack_at) ? (3'b001 << busy) : 3'b000;
      tests++;
      if (got_ack !== exp_ack) begin fails++; $display("FAIL rand_ack cyc=%0d got=%b want=%b", cyc, got_ack, exp_ack); end
      exp_mcs = (cyc >= bus_lo && cyc <= bus_hi);
      tests++;
      if (vif.mcs !== exp_mcs || (exp_mcs && vif.ma_out !== exp_addr)) begin
        fails++; $display("FAIL rand_bus cyc=%0d mcs=%b ma=%h want %b %h", cyc, vif.mcs, vif.ma_out, exp_mcs, exp_addr);
      end
      if (cyc == ack_at) begin
        tests++;
        if (vif.rdata !== exp_rdata) begin fails++; $display("FAIL rand_rdata cyc=%0d got=%h want=%h", cyc, vif.rdata, exp_rdata); end
        active[busy] = 1'b0;
        set_req(busy, 1'b0, 1'b0, 13'h0, 8'h00);
      end
      vif.ppu_mode3 = ($urandom_range(0, 3) == 0);
      if (cyc < 350) begin
        for (int p = 0; p < 3; p++) begin
          if (!active[p] && !(cyc == ack_at && p == busy) && $urandom_range(0, 3) == 0) begin
            active[p] = 1'b1;
            t_addr[p] = 13'h0100 + 13'($urandom_range(0, 15));
            if (p == 2) begin t_we = $urandom_range(0, 1); t_wdata = 8'($urandom); end
            set_req(p, 1'b1, t_we, t_addr[p], t_wdata);
          end
        end
      end
      if (cyc >= free_at && (active[0] || active[1] || active[2])) begin
        win = active[0] ? 0 : (active[1] ? 1 : 2);
        byp = 1'b0;
`ifdef DMG_VRAM_LOCK_EN
        byp = (win == 2) && (vif.ppu_mode3 || active[1]);
`endif
        busy = win;
        if (byp) begin
          ack_at = cyc + 1; bus_lo = 1; bus_hi = 0;
          if (!t_we) exp_rdata = 8'hFF;
        end else begin
          ack_at = cyc + 3; bus_lo = cyc + 1; bus_hi = cyc + 2;
          exp_addr = t_addr[win];
          if (win == 2 && t_we) ref_mem[t_addr[win]] = t_wdata;
          else exp_rdata = ref_mem[t_addr[win]];
        end
        free_at = ack_at + 1;
      end
      @(posedge clk1); @(negedge clk1);
    end
    left = 0;
    for (int p = 0; p < 3; p++) if (active[p]) left++;
    tests++;
    if (left != 0) begin fails++; $display("FAIL rand_drain pending=%0d want=0", left); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_back_to_back();
    test_lock();
    test_reset_in_data();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
